// File: rtl/video_sig_gen.sv
// Raster timing generator: free-running pixel/line counters with registered
// sync, active-draw, new-frame and frame-count outputs for the HDMI path.
module video_sig_gen #(
  parameter int   ACTIVE_H = 1280,
  parameter int   FP_H     = 110,
  parameter int   SYNC_H   = 40,
  parameter int   BP_H     = 220,
  parameter int   ACTIVE_V = 720,
  parameter int   FP_V     = 5,
  parameter int   SYNC_V   = 5,
  parameter int   BP_V     = 20,
  parameter int   FPS      = 60,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out,
  output logic        hs_out,
  output logic        vs_out,
  output logic        ad_out,
  output logic        nf_out,
  output logic [5:0]  fc_out
);

  localparam int TOTAL_H = ACTIVE_H + FP_H + SYNC_H + BP_H;
  localparam int TOTAL_V = ACTIVE_V + FP_V + SYNC_V + BP_V;
  localparam int HS_BEG  = ACTIVE_H + FP_H;
  localparam int HS_END  = HS_BEG + SYNC_H;
  localparam int VS_BEG  = ACTIVE_V + FP_V;
  localparam int VS_END  = VS_BEG + SYNC_V;

  localparam logic [10:0] H_LAST  = 11'(TOTAL_H - 1);
  localparam logic [9:0]  V_LAST  = 10'(TOTAL_V - 1);
  localparam logic [5:0]  FC_LAST = 6'(FPS - 1);

  if (TOTAL_H > 2048) begin : g_chk_h
    $error("TOTAL_H does not fit the 11-bit hcount_out");
  end
  if (TOTAL_V > 1024) begin : g_chk_v
    $error("TOTAL_V does not fit the 10-bit vcount_out");
  end
  if (FPS > 64) begin : g_chk_fps
    $error("FPS does not fit the 6-bit fc_out");
  end

  logic        running_q, running_d;
  logic [10:0] hcount_q, hcount_d;
  logic [9:0]  vcount_q, vcount_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        ad_q, ad_d;
  logic        nf_q, nf_d;
  logic [5:0]  fc_q, fc_d;

  // Outputs are decoded from the next position so every flag lines up with
  // the counters it describes in the same cycle.
  always_comb begin
    running_d = 1'b1;
    hcount_d  = hcount_q;
    vcount_d  = vcount_q;
    if (!running_q) begin
      hcount_d = '0;
      vcount_d = '0;
    end else if (hcount_q == H_LAST) begin
      hcount_d = '0;
      vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 10'd1;
    end else begin
      hcount_d = hcount_q + 11'd1;
    end

    hs_d = ((32'(hcount_d) >= 32'(HS_BEG)) && (32'(hcount_d) < 32'(HS_END)))
           ? SYNC_POL : ~SYNC_POL;
    vs_d = ((32'(vcount_d) >= 32'(VS_BEG)) && (32'(vcount_d) < 32'(VS_END)))
           ? SYNC_POL : ~SYNC_POL;
    ad_d = (32'(hcount_d) < 32'(ACTIVE_H)) && (32'(vcount_d) < 32'(ACTIVE_V));
    nf_d = (32'(hcount_d) == 32'(ACTIVE_H)) && (32'(vcount_d) == 32'(ACTIVE_V));

    fc_d = fc_q;
    if (nf_d) begin
      fc_d = (fc_q == FC_LAST) ? '0 : fc_q + 6'd1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      running_q <= 1'b0;
      hcount_q  <= '0;
      vcount_q  <= '0;
      hs_q      <= ~SYNC_POL;
      vs_q      <= ~SYNC_POL;
      ad_q      <= 1'b0;
      nf_q      <= 1'b0;
      fc_q      <= '0;
    end else begin
      running_q <= running_d;
      hcount_q  <= hcount_d;
      vcount_q  <= vcount_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      ad_q      <= ad_d;
      nf_q      <= nf_d;
      fc_q      <= fc_d;
    end
  end

  assign hcount_out = hcount_q;
  assign vcount_out = vcount_q;
  assign hs_out     = hs_q;
  assign vs_out     = vs_q;
  assign ad_out     = ad_q;
  assign nf_out     = nf_q;
  assign fc_out     = fc_q;

endmodule
